// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external combinational ALU, with one operation in flight at a time.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req0Valid,
  input  logic [31:0] Req0A,
  input  logic [31:0] Req0B,
  input  logic [3:0]  Req0Ctrl,
  output logic        Req0Ready,
  input  logic        Req1Valid,
  input  logic [31:0] Req1A,
  input  logic [31:0] Req1B,
  input  logic [3:0]  Req1Ctrl,
  output logic        Req1Ready,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [3:0]  AluCtrl,
  input  logic [31:0] AluOut,
  output logic        RespValid,
  output logic        RespTag,
  output logic [31:0] RespData,
  input  logic        RespReady
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        idx_q, idx_d, tag_q, tag_d;
  logic        grant, accept;
`ifdef ALU_ARB_RR_EN
  logic        ptr_q, ptr_d;
  assign grant = (Req0Valid & Req1Valid) ? ptr_q : Req1Valid;
`else
  assign grant = ~Req0Valid;
`endif
  // Ready is gated by rst so both stay low throughout reset
  assign Req0Ready = (state_q == IDLE) & ~rst & Req0Valid & ~grant;
  assign Req1Ready = (state_q == IDLE) & ~rst & Req1Valid & grant;
  assign accept    = Req0Ready | Req1Ready;
  assign AluA      = a_q;
  assign AluB      = b_q;
  assign AluCtrl   = ctrl_q;
  assign RespValid = state_q == RESP;
  assign RespTag   = tag_q;
  assign RespData  = data_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tag_d   = tag_q;
    state_d = state_q == IDLE ? (accept ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (RespReady ? IDLE : RESP);
    a_d     = accept ? (grant ? Req1A : Req0A) : a_q;
    b_d     = accept ? (grant ? Req1B : Req0B) : b_q;
    ctrl_d  = accept ? (grant ? Req1Ctrl : Req0Ctrl) : ctrl_q;
    idx_d   = accept ? grant : idx_q;
    data_d  = state_q == EXEC ? AluOut : data_q;
    tag_d   = state_q == EXEC ? idx_q : tag_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 4'b1111;
      idx_q   <= 1'b0;
      data_q  <= '0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end
`ifdef ALU_ARB_RR_EN
  // Pointer names the requester preferred on the next tie: the one just passed over
  assign ptr_d = accept ? ~grant : ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [31:0] Req0A, Req0B, Req1A, Req1B;
  logic [3:0]  Req0Ctrl, Req1Ctrl, AluCtrl;
  logic [31:0] AluA, AluB, AluOut, RespData;
  logic        RespValid, RespTag, RespReady;
  typedef struct packed {
    logic        tag;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] cyc;
  } op_t;
  op_t         sb[$];
  logic        tag_log[$];
  logic [31:0] data_log[$];
  int          checks = 0, failures = 0, cyc = 0, hold = 0, n_before = 0;
  logic        rst_r = 1'b1, ptr_m = 1'b0, prev_v = 1'b0, prev_tag = 1'b0;
  logic [31:0] prev_data = '0;
  logic        v[2], cont[2];
  logic [31:0] ra[2], rb[2];
  logic [3:0]  rc[2];

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .Req0Valid(Req0Valid), .Req0A(Req0A), .Req0B(Req0B), .Req0Ctrl(Req0Ctrl), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1A(Req1A), .Req1B(Req1B), .Req1Ctrl(Req1Ctrl), .Req1Ready(Req1Ready),
    .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluOut(AluOut),
    .RespValid(RespValid), .RespTag(RespTag), .RespData(RespData), .RespReady(RespReady)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    return c == 4'he ? a + b : c == 4'hd ? b - a : c == 4'hf ? b : a ^ b;
  endfunction

  assign AluOut = alu_f(AluA, AluB, AluCtrl);
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    v[i] = 1'b1; ra[i] = a; rb[i] = b; rc[i] = c;
  endtask

  task automatic rand_req(input int i);
    set_req(i, $urandom, $urandom, 4'($urandom_range(12, 15)));
  endtask

  // One clock: drive at negedge, sample 1 time unit later, predict the next posedge
  task automatic cycle();
    logic idle, g, e0, e1, ev;
    @(negedge clk);
    cyc++;
    rst = rst_r;
    Req0Valid = v[0]; Req0A = ra[0]; Req0B = rb[0]; Req0Ctrl = rc[0];
    Req1Valid = v[1]; Req1A = ra[1]; Req1B = rb[1]; Req1Ctrl = rc[1];
    RespReady = !(RespValid === 1'b1 && hold > 0);
    if (RespValid === 1'b1 && hold > 0) hold--;
    #1;
    if (rst) begin
      sb.delete();
      ptr_m = 1'b0;
      prev_v = 1'b0;
    end
    idle = sb.size() == 0;
    if (!idle) begin
      check("alu_a", 64'(AluA), 64'(sb[0].a));
      check("alu_b", 64'(AluB), 64'(sb[0].b));
      check("alu_ctrl", 64'(AluCtrl), 64'(sb[0].ctrl));
    end
    ev = !idle && (cyc - int'(sb[0].cyc) >= 2);
    check("resp_valid", 64'(RespValid), 64'(ev));
    if (RespValid && ev) begin
      if (prev_v) begin
        check("hold_data", 64'(RespData), 64'(prev_data));
        check("hold_tag", 64'(RespTag), 64'(prev_tag));
      end
      if (RespReady) begin
        check("resp_tag", 64'(RespTag), 64'(sb[0].tag));
        check("resp_data", 64'(RespData), 64'(sb[0].data));
        tag_log.push_back(RespTag);
        data_log.push_back(RespData);
        void'(sb.pop_front());
      end
    end
    prev_v = RespValid && !RespReady;
    prev_data = RespData;
    prev_tag = RespTag;
`ifdef ALU_ARB_RR_EN
    g = (v[0] && v[1]) ? ptr_m : v[1];
`else
    g = !v[0];
`endif
    e0 = idle && !rst && v[0] && !g;
    e1 = idle && !rst && v[1] && g;
    check("ready", 64'({Req1Ready, Req0Ready}), 64'({e1, e0}));
    if (e0 || e1) begin
      sb.push_back('{g, alu_f(ra[g], rb[g], rc[g]), ra[g], rb[g], rc[g], 32'(cyc)});
      ptr_m = !g;
      if (cont[g]) rand_req(int'(g));
      else v[g] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      cycle();
      done = sb.size() == 0 && !v[0] && !v[1];
    end
    check("idle_timeout", 64'(done), 64'(1));
  endtask

  task automatic check_reset();
    check("rst_valid", 64'(RespValid), 64'(0));
    check("rst_tag", 64'(RespTag), 64'(0));
    check("rst_data", 64'(RespData), 64'(0));
    check("rst_alu_a", 64'(AluA), 64'(0));
    check("rst_alu_b", 64'(AluB), 64'(0));
    check("rst_alu_ctrl", 64'(AluCtrl), 64'(4'hf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    Req0Valid = 1'b0; Req0A = '0; Req0B = '0; Req0Ctrl = '0;
    Req1Valid = 1'b0; Req1A = '0; Req1B = '0; Req1Ctrl = '0;
    RespReady = 1'b1;
    v = '{1'b1, 1'b1};
    cont = '{1'b0, 1'b0};
    ra = '{32'd0, 32'd0}; rb = '{32'd0, 32'd0}; rc = '{4'd0, 4'd0};
    cycle();
    cycle();
    check_reset();
    v = '{1'b0, 1'b0};
    rst_r = 1'b0;
    set_req(0, 32'd3, 32'd5, 4'he);
    wait_idle(10);
    check("single_data", 64'(data_log[$]), 64'(8));
    check("single_tag", 64'(tag_log[$]), 64'(0));
    rst_r = 1'b1;
    cycle();
    rst_r = 1'b0;
    tag_log.delete();
    cont = '{1'b1, 1'b1};
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 40 && tag_log.size() < 4; i++) cycle();
    cont = '{1'b0, 1'b0};
    v = '{1'b0, 1'b0};
    wait_idle(10);
    check("cont_count", 64'(tag_log.size() >= 4), 64'(1));
`ifdef ALU_ARB_RR_EN
    check("cont_seq", 64'({tag_log[0], tag_log[1], tag_log[2], tag_log[3]}), 64'(4'b0101));
`else
    check("cont_seq", 64'({tag_log[0], tag_log[1], tag_log[2], tag_log[3]}), 64'(4'b0000));
`endif
    hold = 5;
    set_req(0, 32'd7, 32'd9, 4'he);
    cycle();
    set_req(1, 32'd4, 32'd6, 4'hc);
    wait_idle(20);
    check("bp_hold", 64'(hold), 64'(0));
    check("bp_tag", 64'(tag_log[$]), 64'(1));
    check("bp_data", 64'(data_log[$]), 64'(2));
    set_req(0, 32'd11, 32'd22, 4'he);
    cycle();
    rst_r = 1'b1;
    cycle();
    check_reset();
    rst_r = 1'b0;
    n_before = tag_log.size();
    set_req(1, 32'd2, 32'd10, 4'hd);
    wait_idle(10);
    check("sub_data", 64'(data_log[$]), 64'(8));
    check("sub_tag", 64'(tag_log[$]), 64'(1));
    check("abort_count", 64'(tag_log.size()), 64'(n_before + 1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; all datapaths are 32 bits and ALU control is 4 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 Req0Valid  in  1  requester 0 has an operation pending.
REQ-005 Req0A / Req0B  in  32 each  requester 0 operands.
REQ-006 Req0Ctrl  in  4  requester 0 ALU operation code.
REQ-007 Req0Ready  out  1  requester 0 operation accepted this cycle.
REQ-008 Req1Valid, Req1A, Req1B, Req1Ctrl, Req1Ready SHALL be identical in direction, width and meaning for requester 1.
REQ-009 AluA / AluB  out  32 each  operands driven to the shared ALU.
REQ-010 AluCtrl  out  4  operation code driven to the shared ALU.
REQ-011 AluOut  in  32  combinational ALU result.
REQ-012 RespValid  out  1  result available.
REQ-013 RespTag  out  1  requester index owning the result.
REQ-014 RespData  out  32  captured ALU result.
REQ-015 RespReady  in  1  consumer accepts the result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-017 In IDLE, ReqNReady SHALL be asserted combinationally only for the granted requester, and only when that requester's ReqNValid is high.
REQ-018 On an accept, the block SHALL register A, B, Ctrl and the requester index, then move to EXEC.
REQ-019 AluA, AluB and AluCtrl SHALL come only from the operand registers, never from the request inputs directly.
REQ-020 In EXEC, the block SHALL capture AluOut into RespData and the index into RespTag, then move to RESP.
REQ-021 In RESP, RespValid SHALL be 1, and RespData and RespTag SHALL stay stable until a cycle with RespReady=1; that cycle SHALL return the FSM to IDLE.
REQ-022 The first possible RespValid after an accept in cycle N SHALL be cycle N+2.
REQ-023 No request SHALL be accepted in EXEC or RESP; at most one operation SHALL be in flight.
REQ-024 A new accept SHALL be possible in the cycle after RESP completes, giving a peak rate of one operation per 3 cycles.
REQ-025 If only one requester is valid in IDLE, that requester SHALL be granted.
REQ-026 If both requesters are valid in IDLE, the grant SHALL follow the arbitration policy of REQ-031/REQ-032.
REQ-027 Requesters SHALL hold Valid and operands stable until Ready; a Valid that drops before Ready SHALL be ignored with no state change.
REQ-028 RespReady asserted outside RESP SHALL have no effect.

Reset
REQ-029 While rst=1, the following SHALL hold: state=IDLE, RespValid=0, RespTag=0, RespData=0, AluA=0, AluB=0, AluCtrl=4'b1111 (pass-through B), priority pointer=0, and both ReqNReady=0.
REQ-030 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response; the first accept SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-031 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin:
- a 1-bit pointer names the preferred requester;
- on each accept the pointer SHALL become the index not granted;
- the pointer SHALL wrap 1 to 0.
REQ-032 Without ALU_ARB_RR_EN, requester 0 SHALL always win a simultaneous request, and no pointer register SHALL exist.

Verification
REQ-033 Single op: Req0 valid, A=3, B=5, Ctrl=4'b1110, RespReady=1 -> Req0Ready in cycle 0, RespValid in cycle 2 with RespData=8 and RespTag=0, back in IDLE in cycle 3.
REQ-034 Contention with ALU_ARB_RR_EN: both requesters valid continuously, RespReady=1 -> RespTag sequence 0,1,0,1; without the macro -> 0,0,0,0 and Req1 never served.
REQ-035 Back-pressure: RespReady=0 for 5 cycles after RespValid, Req1 valid throughout -> RespData/RespTag constant, Req1Ready=0 throughout, Req1 accepted the cycle after RespReady=1.
REQ-036 Reset mid-op: assert rst during EXEC -> RespValid=0, all outputs at reset values, no response for the aborted op, next request served normally.
REQ-037 Subtract order: Req1 valid, A=2, B=10, Ctrl=4'b1101 -> RespData=8, RespTag=1; AluA/AluB stay stable through EXEC.
